// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with req/ack data bus and MEM/WB register.
// Formats loads/stores, stalls upstream while a bus access is open, aborts on timeout.
//
// Ports:
//   clk, rst (async, active low)
//   EXE/MEM in : valid_in, alu_res_in, store_data_in, pc8_in, mem_re_in,
//                mem_we_in, mem_size_in, mem_sign_in, wdata_src_in,
//                reg_we_in, reg_addr_in
//   bus        : dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
//                dmem_ack, dmem_rdata
//   control    : stall_out
//   MEM/WB out : wb_valid, wb_reg_we, wb_addr, wb_data, addr_err, bus_err
// Build option: MEM_STAGE_ALIGN_CHECK_EN enables misaligned-access trapping.

module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] pc8_in,
  input  logic        mem_re_in,
  input  logic        mem_we_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_sign_in,
  input  logic [1:0]  wdata_src_in,
  input  logic        reg_we_in,
  input  logic [4:0]  reg_addr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        wb_valid,
  output logic        wb_reg_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        addr_err,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam int CW = 10;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  logic [31:0] l_addr;
  logic [31:0] l_pc8;
  logic [1:0]  l_size;
  logic [1:0]  l_src;
  logic        l_sign;
  logic        l_reg_we;
  logic [4:0]  l_rd;

  logic        mem_op;
  logic        aligned;
  logic        timeout_hit;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    unique case (1'b1)
      sz == 2'b00: lane_mask = 4'b0001 << a;
      sz == 2'b01: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default:     lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_fmt(
    input logic [1:0]  sz,
    input logic [31:0] sd
  );
    unique case (1'b1)
      sz == 2'b00: st_fmt = {4{sd[7:0]}};
      sz == 2'b01: st_fmt = {2{sd[15:0]}};
      default:     st_fmt = sd;
    endcase
  endfunction

  function automatic logic [31:0] wb_pick(
    input logic [1:0]  src,
    input logic [31:0] alu,
    input logic [31:0] ld,
    input logic [31:0] pc8
  );
    unique case (1'b1)
      src == 2'b01: wb_pick = ld;
      src == 2'b10: wb_pick = pc8;
      default:      wb_pick = alu;
    endcase
  endfunction

  assign mem_op = valid_in & (mem_re_in | mem_we_in);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  assign aligned = ~((mem_size_in == 2'b01 & alu_res_in[0]) |
                     (mem_size_in[1] & (|alu_res_in[1:0])));
`else
  assign aligned = 1'b1;
`endif

  assign timeout_hit = (state == BUS) & (cnt == TO_LAST);

  // Gated by rst so the stall drops the moment reset asserts.
  assign stall_out = rst &
    (((state == IDLE) & mem_op & aligned) |
     ((state == BUS) & ~dmem_ack & ~timeout_hit));

  always_comb begin
    ld_b = dmem_rdata[{l_addr[1:0], 3'b000} +: 8];
    ld_h = l_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (1'b1)
      l_size == 2'b00: ld_data = {{24{l_sign & ld_b[7]}}, ld_b};
      l_size == 2'b01: ld_data = {{16{l_sign & ld_h[15]}}, ld_h};
      default:         ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      l_addr     <= '0;
      l_pc8      <= '0;
      l_size     <= '0;
      l_src      <= '0;
      l_sign     <= 1'b0;
      l_reg_we   <= 1'b0;
      l_rd       <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      wb_valid   <= 1'b0;
      wb_reg_we  <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_op & aligned) begin
            state      <= BUS;
            cnt        <= '0;
            l_addr     <= alu_res_in;
            l_pc8      <= pc8_in;
            l_size     <= mem_size_in;
            l_src      <= wdata_src_in;
            l_sign     <= mem_sign_in;
            l_reg_we   <= reg_we_in;
            l_rd       <= reg_addr_in;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_we_in;
            dmem_addr  <= {alu_res_in[31:2], 2'b00};
            dmem_be    <= lane_mask(mem_size_in, alu_res_in[1:0]);
            dmem_wdata <= st_fmt(mem_size_in, store_data_in);
            wb_valid   <= 1'b0;
            wb_reg_we  <= 1'b0;
          end else begin
            // Here a memory op can only be a trapped misaligned one.
            wb_valid  <= valid_in;
            wb_reg_we <= valid_in & reg_we_in & ~mem_op;
            wb_addr   <= reg_addr_in;
            wb_data   <= wb_pick(wdata_src_in, alu_res_in,
                                 ld_data, pc8_in);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            addr_err  <= mem_op;
`endif
          end
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          if (dmem_ack | timeout_hit) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b1;
            wb_reg_we  <= l_reg_we & dmem_ack;
            wb_addr    <= l_rd;
            wb_data    <= wb_pick(l_src, l_addr, ld_data, l_pc8);
            bus_err    <= ~dmem_ack;
          end else begin
            wb_valid  <= 1'b0;
            wb_reg_we <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level
// writeback model and a per-cycle MEM/WB compare process.

module tb_mem_stage;

  localparam int TO = 8;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic        re;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  src;
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc8;
  } op_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        we;
    logic        aerr;
    logic        berr;
    logic        chk;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] alu_res_in = '0;
  logic [31:0] store_data_in = '0;
  logic [31:0] pc8_in = '0;
  logic        mem_re_in = 1'b0;
  logic        mem_we_in = 1'b0;
  logic [1:0]  mem_size_in = '0;
  logic        mem_sign_in = 1'b0;
  logic [1:0]  wdata_src_in = '0;
  logic        reg_we_in = 1'b0;
  logic [4:0]  reg_addr_in = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_out;
  logic        wb_valid;
  logic        wb_reg_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        addr_err;
  logic        bus_err;

  int          total = 0;
  int          bad = 0;
  logic [31:0] cyc = '0;
  exp_t        q[$];
  exp_t        ce;
  int          reqn;
  logic [31:0] seen_addr;
  logic [3:0]  seen_be;
  logic [31:0] seen_wd;
  logic        seen_we;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .alu_res_in(alu_res_in),
    .store_data_in(store_data_in), .pc8_in(pc8_in),
    .mem_re_in(mem_re_in), .mem_we_in(mem_we_in),
    .mem_size_in(mem_size_in), .mem_sign_in(mem_sign_in),
    .wdata_src_in(wdata_src_in), .reg_we_in(reg_we_in),
    .reg_addr_in(reg_addr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out),
    .wb_valid(wb_valid), .wb_reg_we(wb_reg_we),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", n, act, req, cyc);
    end
  endtask

  function automatic op_t mk(
    input logic v, input logic re, input logic we,
    input logic [1:0] sz, input logic sg, input logic [1:0] src,
    input logic rwe, input logic [4:0] rd,
    input logic [31:0] alu, input logic [31:0] sd,
    input logic [31:0] pc8);
    op_t o;
    o.valid = v; o.re = re; o.we = we; o.size = sz; o.sign = sg;
    o.src = src; o.reg_we = rwe; o.rd = rd;
    o.alu = alu; o.sd = sd; o.pc8 = pc8;
    return o;
  endfunction

  function automatic bit is_mis(input op_t o);
    int unsigned a;
    a = o.alu % 4;
    if (!ALIGN) return 1'b0;
    if (o.size == 2'd1) return (a % 2) != 0;
    if (o.size >= 2'd2) return a != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input op_t o);
    int unsigned a;
    a = o.alu % 4;
    if (o.size == 2'd0) return 4'(1 << a);
    if (o.size == 2'd1) return (a >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wd(input op_t o);
    if (o.size == 2'd0) return (o.sd & 32'hFF) * 32'h01010101;
    if (o.size == 2'd1) return (o.sd & 32'hFFFF) * 32'h00010001;
    return o.sd;
  endfunction

  function automatic exp_t model(input op_t o, input logic [31:0] rd,
                                 input bit tmo);
    exp_t e;
    int unsigned a;
    logic [31:0] v;
    e.cyc = '0; e.we = 1'b0; e.aerr = 1'b0; e.berr = 1'b0;
    e.chk = 1'b1; e.rd = o.rd; e.data = '0;
    if (is_mis(o)) begin
      e.aerr = 1'b1; e.chk = 1'b0; return e;
    end
    if (tmo) begin
      e.berr = 1'b1; e.chk = 1'b0; return e;
    end
    e.we = o.reg_we;
    a = o.alu % 4;
    if (o.size == 2'd0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (o.sign && v >= 128) v = v - 256;
    end else if (o.size == 2'd1) begin
      v = (rd >> (16 * (a / 2))) & 32'hFFFF;
      if (o.sign && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    if (o.src == 2'd1) e.data = v;
    else if (o.src == 2'd2) e.data = o.pc8;
    else e.data = o.alu;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (q.size() != 0 && q[0].cyc == cyc) begin
        ce = q.pop_front();
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_reg_we", 32'(wb_reg_we), 32'(ce.we));
        chk("wb_addr", 32'(wb_addr), 32'(ce.rd));
        if (ce.chk) chk("wb_data", wb_data, ce.data);
        chk("addr_err", 32'(addr_err), 32'(ce.aerr));
        chk("bus_err", 32'(bus_err), 32'(ce.berr));
      end else begin
        chk("wb_bubble", {29'd0, wb_valid, addr_err, bus_err}, 32'd0);
      end
    end
  end

  task automatic drive(input op_t o);
    valid_in = o.valid; mem_re_in = o.re; mem_we_in = o.we;
    mem_size_in = o.size; mem_sign_in = o.sign;
    wdata_src_in = o.src; reg_we_in = o.reg_we;
    reg_addr_in = o.rd; alu_res_in = o.alu;
    store_data_in = o.sd; pc8_in = o.pc8;
  endtask

  // Called just after a rising edge; returns just after the edge that
  // loads MEM/WB for this instruction. ack_k = 0 means never ack.
  task automatic run_op(input op_t o, input int ack_k,
                        input logic [31:0] rd);
    exp_t e;
    bit   done;
    reqn = 0;
    drive(o);
    if (!(o.valid && (o.re || o.we)) || is_mis(o)) begin
      e = model(o, dmem_rdata, 1'b0);
      e.cyc = cyc + 1;
      q.push_back(e);
      #1;
      chk("stall_idle", 32'(stall_out), 32'd0);
      chk("req_idle", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    #1;
    chk("stall_accept", 32'(stall_out), 32'd1);
    @(posedge clk); #1;
    done = 1'b0;
    for (int k = 1; k <= TO + 1; k++) begin
      chk("dmem_req", 32'(dmem_req), 32'd1);
      chk("dmem_addr", dmem_addr, o.alu & 32'hFFFF_FFFC);
      chk("dmem_be", 32'(dmem_be), 32'(exp_be(o)));
      chk("dmem_we", 32'(dmem_we), 32'(o.we));
      if (o.we) chk("dmem_wdata", dmem_wdata, exp_wd(o));
      if (dmem_req) reqn++;
      if (k == 1) begin
        seen_addr = dmem_addr; seen_be = dmem_be;
        seen_wd = dmem_wdata; seen_we = dmem_we;
      end
      if (k == ack_k) begin
        dmem_ack = 1'b1; dmem_rdata = rd;
        #1;
        chk("stall_ack", 32'(stall_out), 32'd0);
        e = model(o, rd, 1'b0);
        e.cyc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        done = 1'b1;
      end else begin
        dmem_rdata = ~rd;
        #1;
        chk("stall_bus", 32'(stall_out), 32'(k < TO));
        if (k == TO) begin
          e = model(o, rd, 1'b1);
          e.cyc = cyc + 1;
          q.push_back(e);
          done = 1'b1;
        end
        @(posedge clk); #1;
      end
      if (done) break;
    end
    if (!done) chk("bus_bound", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  op_t o;

  initial begin
    valid_in = 1'b1;
    mem_re_in = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb", {26'd0, wb_valid, wb_reg_we, addr_err, bus_err,
                   stall_out, 1'b0}, 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    valid_in = 1'b0;
    mem_re_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // word load, ack in 3rd BUS cycle, then back-to-back ALU op
    o = mk(1,1,0,2'd2,0,2'd1,1,5'd5,32'h100,0,0);
    run_op(o, 3, 32'hDEADBEEF);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_reg_we", 32'(wb_reg_we), 32'd1);
    o = mk(1,0,0,2'd0,0,2'd0,1,5'd6,32'h55,0,0);
    run_op(o, 0, 0);
    chk("alu_b2b", wb_data, 32'h55);

    // signed / unsigned byte loads at 0x103
    o = mk(1,1,0,2'd0,1,2'd1,1,5'd7,32'h103,0,0);
    run_op(o, 1, 32'h80112233);
    chk("lb_signed", wb_data, 32'hFFFFFF80);
    o = mk(1,1,0,2'd0,0,2'd1,1,5'd8,32'h103,0,0);
    run_op(o, 1, 32'h80112233);
    chk("lb_unsigned", wb_data, 32'h00000080);

    // store half at 0x202
    o = mk(1,0,1,2'd1,0,2'd0,0,5'd0,32'h202,32'h1234ABCD,0);
    run_op(o, 2, 0);
    chk("sh_be", 32'(seen_be), 32'hC);
    chk("sh_wdata", seen_wd, 32'hABCDABCD);
    chk("sh_we", 32'(seen_we), 32'd1);
    chk("sh_req_drop", 32'(dmem_req), 32'd0);

    // store byte lane 3, signed half load upper lane, link op
    o = mk(1,0,1,2'd0,0,2'd0,0,5'd0,32'h103,32'h000000A5,0);
    run_op(o, 1, 0);
    o = mk(1,1,0,2'd1,1,2'd1,1,5'd10,32'h102,0,0);
    run_op(o, 2, 32'h80017FFF);
    o = mk(1,0,0,2'd0,0,2'd2,1,5'd31,32'h4,0,32'h1008);
    run_op(o, 0, 0);
    chk("link_data", wb_data, 32'h1008);

    // both re and we high behaves as a store
    o = mk(1,1,1,2'd2,0,2'd0,0,5'd0,32'h10,32'hCAFEF00D,0);
    run_op(o, 1, 0);

    // timeout: no ack ever
    o = mk(1,1,0,2'd2,0,2'd1,1,5'd12,32'h400,0,0);
    run_op(o, 0, 32'h11111111);
    chk("tmo_req_cycles", 32'(reqn), 32'd8);
    chk("tmo_req_drop", 32'(dmem_req), 32'd0);

    // ack outside BUS is ignored
    dmem_ack = 1'b1;
    o = mk(1,0,0,2'd0,0,2'd3,1,5'd13,32'h777,0,0);
    run_op(o, 0, 0);
    dmem_ack = 1'b0;
    chk("stray_ack", wb_data, 32'h777);

    // word load at 0x101
    o = mk(1,1,0,2'd2,0,2'd1,1,5'd9,32'h101,0,0);
    run_op(o, 1, 32'h0BADF00D);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    chk("mis_no_req", 32'(reqn), 32'd0);
`else
    chk("unal_addr", seen_addr, 32'h100);
    chk("unal_be", 32'(seen_be), 32'hF);
`endif

    // invalid mem op does nothing
    valid_in = 1'b0; mem_re_in = 1'b1;
    #1 chk("inv_no_stall", 32'(stall_out), 32'd0);
    idle(2);

    // reset in the middle of a bus access
    o = mk(1,1,0,2'd2,0,2'd1,1,5'd14,32'h300,0,0);
    drive(o);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_req", 32'(dmem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall_out), 32'd0);
    valid_in = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    o = mk(1,0,0,2'd0,0,2'd0,1,5'd15,32'hA5A5,0,0);
    run_op(o, 0, 0);
    chk("post_rst_alu1", wb_data, 32'hA5A5);
    o = mk(1,0,0,2'd0,0,2'd0,1,5'd16,32'h5A5A,0,0);
    run_op(o, 0, 0);
    chk("post_rst_alu2", wb_data, 32'h5A5A);
    idle(3);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
